// File: rtl/fifo_controller_if.sv
// Handshake and datapath-control bundle for fifo_controller.
// master: the controller side (drives grants, acks, strobes, muxed data).
// slave:  the producers/consumer/datapath side.
// With FIFO_LEVEL_COUNT_EN defined the bundle also carries level and almost_full.
interface fifo_controller_if #(
  parameter int NUM_BIT   = 4,
  parameter int PAR_WRITE = 1
`ifdef FIFO_LEVEL_COUNT_EN
  ,
  parameter int NUM_REG   = 4
`endif
);
  logic                         wr_req0;
  logic                         wr_req1;
  logic [PAR_WRITE*NUM_BIT-1:0] din0;
  logic [PAR_WRITE*NUM_BIT-1:0] din1;
  logic                         wr_gnt0;
  logic                         wr_gnt1;
  logic                         rd_req;
  logic                         rd_ack;
  logic                         clr;
  logic                         busy;
  logic                         dp_ready;
  logic                         dp_valid;
  logic                         dp_full;
  logic                         dp_empty;
  logic                         dp_init;
  logic                         dp_wen;
  logic                         dp_inc_w;
  logic                         dp_inc_r;
  logic [PAR_WRITE*NUM_BIT-1:0] dp_din;
`ifdef FIFO_LEVEL_COUNT_EN
  logic [$clog2(NUM_REG):0]     level;
  logic                         almost_full;
`endif

  modport master (
    input  wr_req0, wr_req1, din0, din1, rd_req, clr,
    input  dp_ready, dp_valid, dp_full, dp_empty,
    output wr_gnt0, wr_gnt1, rd_ack, busy,
    output dp_init, dp_wen, dp_inc_w, dp_inc_r, dp_din
`ifdef FIFO_LEVEL_COUNT_EN
    ,
    output level, almost_full
`endif
  );

  modport slave (
    output wr_req0, wr_req1, din0, din1, rd_req, clr,
    output dp_ready, dp_valid, dp_full, dp_empty,
    input  wr_gnt0, wr_gnt1, rd_ack, busy,
    input  dp_init, dp_wen, dp_inc_w, dp_inc_r, dp_din
`ifdef FIFO_LEVEL_COUNT_EN
    ,
    input  level, almost_full
`endif
  );
endinterface

// File: rtl/fifo_controller.sv
// fifo_controller: sequences init/wen/inc_w/inc_r for the parallel FIFO datapath.
// Two producers share the write port through a round-robin arbiter; one consumer
// drains with req/ack. clr re-initialises the datapath pointers via S_FLUSH.
// Optional macro FIFO_LEVEL_COUNT_EN adds a level counter and almost_full flag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_INIT  | first cycle after reset release; pointer init strobe, busy
// S_RUN   | normal operation; write arbitration and read handshake
// S_FLUSH | one-cycle pointer re-init after clr; arbiter history kept
module fifo_controller #(
  parameter int NUM_BIT   = 4,
  parameter int NUM_REG   = 4,
  parameter int PAR_WRITE = 1,
  parameter int PAR_READ  = 2
) (
  input  logic              clk,
  input  logic              rst,
  fifo_controller_if.master bus
);
  localparam int DIN_W = PAR_WRITE * NUM_BIT;

  if (((NUM_REG & (NUM_REG - 1)) != 0) || (PAR_WRITE > NUM_REG) || (PAR_READ > NUM_REG)) begin : g_cfg_bad
    $error("fifo_controller: NUM_REG must be a power of 2 and not smaller than PAR_WRITE/PAR_READ");
  end

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_last;     // last granted producer; 1 gives producer 0 priority
  logic             wr_ok;
  logic             gnt0;
  logic             gnt1;
  logic             ack;
  logic             init_c;
  logic [DIN_W-1:0] din_mux;

  // State register and round-robin history; history only moves on a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_INIT;
      rr_last <= 1'b1;
    end else begin
      state <= state_nxt;
      if (gnt0) begin
        rr_last <= 1'b0;
      end else if (gnt1) begin
        rr_last <= 1'b1;
      end
    end
  end

  // Next state plus same-cycle grants, ack and write-data mux.
  always_comb begin
    state_nxt = state;
    init_c    = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ack       = 1'b0;
    din_mux   = '0;
    wr_ok     = bus.dp_ready & ~bus.dp_full;
    unique case (state)
      S_INIT, S_FLUSH: begin
        init_c    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        din_mux = bus.din0;
        if (bus.clr) begin
          state_nxt = S_FLUSH;
        end else begin
          gnt0 = wr_ok & bus.wr_req0 & (~bus.wr_req1 | rr_last);
          gnt1 = wr_ok & bus.wr_req1 & (~bus.wr_req0 | ~rr_last);
          // Status is the pre-edge view, so this cycle's write cannot enable a read.
          ack  = bus.rd_req & bus.dp_valid & ~bus.dp_empty;
          if (gnt1) begin
            din_mux = bus.din1;
          end
        end
      end
      default: begin
        init_c    = 1'b1;
        state_nxt = S_INIT;
      end
    endcase
  end

  assign bus.wr_gnt0  = gnt0;
  assign bus.wr_gnt1  = gnt1;
  assign bus.dp_wen   = gnt0 | gnt1;
  assign bus.dp_inc_w = gnt0 | gnt1;
  assign bus.rd_ack   = ack;
  assign bus.dp_inc_r = ack;
  assign bus.dp_init  = init_c;
  assign bus.busy     = init_c;
  assign bus.dp_din   = din_mux;

`ifdef FIFO_LEVEL_COUNT_EN
  localparam int LVL_W = $clog2(NUM_REG) + 1;

  logic [LVL_W-1:0] level_q;
  int               level_next_i;

  // Word count: cleared whenever the pointers are (re)initialised, including the clr edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
    end else if ((state != S_RUN) || bus.clr) begin
      level_q <= '0;
    end else begin
      level_q <= level_q + ((gnt0 | gnt1) ? LVL_W'(PAR_WRITE) : '0)
                         - (ack ? LVL_W'(PAR_READ) : '0);
    end
  end

  // Unwrapped next level, used only by the bounds check below.
  always_comb begin
    level_next_i = int'(level_q);
    if (gnt0 | gnt1) level_next_i = level_next_i + PAR_WRITE;
    if (ack)         level_next_i = level_next_i - PAR_READ;
  end

  level_bounds_a: assert property (@(posedge clk) disable iff (!rst)
    (level_next_i >= 0) && (level_next_i <= NUM_REG));

  assign bus.level       = level_q;
  assign bus.almost_full = (level_q >= LVL_W'(NUM_REG - PAR_WRITE));
`endif
endmodule

// File: tb/tb_fifo_controller.sv
// Bench for fifo_controller: directed vectors with literal expectations, plus a
// per-cycle comparison against a behavioural model that tracks datapath
// occupancy as a word count. The datapath status inputs are derived from that
// count, with force flags that can only make status more restrictive.
`timescale 1ns/1ps
module tb_fifo_controller;
  localparam int NUM_BIT   = 4;
  localparam int NUM_REG   = 4;
  localparam int PAR_WRITE = 1;
  localparam int PAR_READ  = 2;

  logic clk = 1'b0;
  logic rst;

  fifo_controller_if #(
    .NUM_BIT(NUM_BIT),
    .PAR_WRITE(PAR_WRITE)
`ifdef FIFO_LEVEL_COUNT_EN
    ,
    .NUM_REG(NUM_REG)
`endif
  ) bus ();

  fifo_controller #(
    .NUM_BIT(NUM_BIT),
    .NUM_REG(NUM_REG),
    .PAR_WRITE(PAR_WRITE),
    .PAR_READ(PAR_READ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // model state
  int occ    = 0;  // words held by the datapath
  int m_last = 1;  // producer granted most recently
  bit m_init = 1;  // current cycle is an init/flush cycle

  bit f_nready = 0;
  bit f_full   = 0;
  bit f_nvalid = 0;
  bit f_empty  = 0;

  assign bus.dp_ready = !f_nready && (occ + PAR_WRITE <= NUM_REG);
  assign bus.dp_full  = f_full || (occ >= NUM_REG);
  assign bus.dp_valid = !f_nvalid && (occ >= PAR_READ);
  assign bus.dp_empty = f_empty || (occ == 0);

  typedef struct packed {
    logic       init;
    logic       gnt0;
    logic       gnt1;
    logic       ack;
    logic [3:0] din;
  } exp_t;

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    if (!rst || m_init) begin
      e.init = 1'b1;
      return e;
    end
    e.din = bus.din0;
    if (bus.clr) return e;
    if (bus.dp_ready && !bus.dp_full) begin
      if (bus.wr_req0 && bus.wr_req1) begin
        if (m_last == 0) e.gnt1 = 1'b1;
        else             e.gnt0 = 1'b1;
      end else if (bus.wr_req0) begin
        e.gnt0 = 1'b1;
      end else if (bus.wr_req1) begin
        e.gnt1 = 1'b1;
      end
    end
    if (e.gnt1) e.din = bus.din1;
    e.ack = bus.rd_req && bus.dp_valid && !bus.dp_empty;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // model update: occupancy, arbiter history, init/flush sequencing
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_init <= 1'b1;
      m_last <= 1;
      occ    <= 0;
    end else begin
      exp_t e;
      e = predict();
      if (m_init) begin
        m_init <= 1'b0;
        occ    <= 0;
      end else if (bus.clr) begin
        m_init <= 1'b1;
        occ    <= 0;
      end else begin
        if (e.gnt0) m_last <= 0;
        if (e.gnt1) m_last <= 1;
        occ <= occ + ((e.gnt0 || e.gnt1) ? PAR_WRITE : 0) - (e.ack ? PAR_READ : 0);
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    e = predict();
    chk("m_dp_init",  bus.dp_init,  e.init);
    chk("m_busy",     bus.busy,     e.init);
    chk("m_wr_gnt0",  bus.wr_gnt0,  e.gnt0);
    chk("m_wr_gnt1",  bus.wr_gnt1,  e.gnt1);
    chk("m_dp_wen",   bus.dp_wen,   e.gnt0 | e.gnt1);
    chk("m_dp_inc_w", bus.dp_inc_w, e.gnt0 | e.gnt1);
    chk("m_rd_ack",   bus.rd_ack,   e.ack);
    chk("m_dp_inc_r", bus.dp_inc_r, e.ack);
    chk("m_dp_din",   bus.dp_din,   e.din);
`ifdef FIFO_LEVEL_COUNT_EN
    chk("m_level",       bus.level,       occ);
    chk("m_almost_full", bus.almost_full, occ >= NUM_REG - PAR_WRITE);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_req0 = 1'b0;
    bus.wr_req1 = 1'b0;
    bus.din0    = '0;
    bus.din1    = '0;
    bus.rd_req  = 1'b0;
    bus.clr     = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset and the single init cycle
    @(negedge clk);
    chk("rst_dp_init", bus.dp_init, 1);
    chk("rst_gnt0",    bus.wr_gnt0, 0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("init_dp_init", bus.dp_init, 1);
    chk("init_busy",    bus.busy,    1);
    cyc();
    @(negedge clk);
    chk("run_dp_init", bus.dp_init, 0);
    chk("run_busy",    bus.busy,    0);
    cyc();

    // arbitration, both producers requesting
    bus.wr_req0 = 1'b1;
    bus.wr_req1 = 1'b1;
    bus.din0    = 4'h3;
    bus.din1    = 4'hA;
    @(negedge clk);
    chk("arb0_gnt0", bus.wr_gnt0, 1);
    chk("arb0_din",  bus.dp_din,  4'h3);
    chk("arb0_wen",  bus.dp_wen,  1);
    cyc();
    @(negedge clk);
    chk("arb1_gnt1", bus.wr_gnt1, 1);
    chk("arb1_din",  bus.dp_din,  4'hA);
    cyc();
    @(negedge clk);
    chk("arb2_gnt0", bus.wr_gnt0, 1);
    chk("arb2_din",  bus.dp_din,  4'h3);
    chk("arb2_incw", bus.dp_inc_w, 1);
    cyc();
    bus.wr_req1 = 1'b0;

    // backpressure with three words stored
    f_nready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_gnt0", bus.wr_gnt0, 0);
      chk("bp_wen",  bus.dp_wen,  0);
      cyc();
    end
    f_nready = 1'b0;
    @(negedge clk);
    chk("bp_release_gnt0", bus.wr_gnt0, 1);
    cyc();
    @(negedge clk);
    chk("full_gnt0", bus.wr_gnt0, 0);
    cyc();
    bus.wr_req0 = 1'b0;

    // read handshake, four words stored
    bus.rd_req = 1'b1;
    f_nvalid   = 1'b1;
    @(negedge clk);
    chk("rd_novalid_ack", bus.rd_ack, 0);
    cyc();
    f_nvalid = 1'b0;
    @(negedge clk);
    chk("rd_ack",   bus.rd_ack,   1);
    chk("rd_inc_r", bus.dp_inc_r, 1);
    cyc();
    f_empty = 1'b1;
    @(negedge clk);
    chk("rd_empty_ack", bus.rd_ack, 0);
    cyc();
    f_empty = 1'b0;
    @(negedge clk);
    chk("rd_ack2", bus.rd_ack, 1);
    cyc();
    @(negedge clk);
    chk("rd_drained_ack", bus.rd_ack, 0);
    cyc();
    bus.rd_req = 1'b0;

    // fill two words, then simultaneous write and read
    bus.wr_req1 = 1'b1;
    @(negedge clk);
    chk("fill_gnt1", bus.wr_gnt1, 1);
    cyc();
    bus.wr_req1 = 1'b0;
    bus.wr_req0 = 1'b1;
    @(negedge clk);
    chk("fill_gnt0", bus.wr_gnt0, 1);
    cyc();
    bus.wr_req0 = 1'b0;
    bus.wr_req1 = 1'b1;
    bus.rd_req  = 1'b1;
    @(negedge clk);
    chk("sim_gnt1",  bus.wr_gnt1,  1);
    chk("sim_inc_w", bus.dp_inc_w, 1);
    chk("sim_ack",   bus.rd_ack,   1);
    chk("sim_inc_r", bus.dp_inc_r, 1);
    chk("sim_din",   bus.dp_din,   4'hA);
`ifdef FIFO_LEVEL_COUNT_EN
    chk("sim_level_before", bus.level, 2);
`endif
    cyc();
    bus.wr_req1 = 1'b0;
    bus.rd_req  = 1'b0;
    @(negedge clk);
`ifdef FIFO_LEVEL_COUNT_EN
    chk("sim_level_after", bus.level, 1);
`endif
    chk("idle_wen", bus.dp_wen, 0);
    cyc();

    // flush during traffic; producer 1 was last, so producer 0 goes first
    bus.wr_req0 = 1'b1;
    bus.wr_req1 = 1'b1;
    @(negedge clk);
    chk("fl_pre_gnt0", bus.wr_gnt0, 1);
    cyc();
    bus.clr = 1'b1;
    @(negedge clk);
    chk("fl_clr_gnt0", bus.wr_gnt0, 0);
    chk("fl_clr_gnt1", bus.wr_gnt1, 0);
    chk("fl_clr_busy", bus.busy,    0);
    cyc();
    bus.clr = 1'b0;
    @(negedge clk);
    chk("fl_init", bus.dp_init, 1);
    chk("fl_busy", bus.busy,    1);
    chk("fl_gnt1", bus.wr_gnt1, 0);
`ifdef FIFO_LEVEL_COUNT_EN
    chk("fl_level", bus.level, 0);
`endif
    cyc();
    @(negedge clk);
    chk("fl_post_gnt1", bus.wr_gnt1, 1);
    chk("fl_post_din",  bus.dp_din,  4'hA);
`ifdef FIFO_LEVEL_COUNT_EN
    chk("fl_post_level", bus.level, 0);
`endif
    cyc();

    // clr held: RUN(blocked)/FLUSH alternate, nothing accepted
    bus.clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clrh_gnt", bus.wr_gnt0 | bus.wr_gnt1, 0);
      chk("clrh_busy", bus.busy, (i % 2 == 1) ? 1 : 0);
      cyc();
    end
    bus.clr = 1'b0;
    @(negedge clk);
    chk("clrh_resume_gnt0", bus.wr_gnt0, 1);
    cyc();
    bus.wr_req1 = 1'b0;

    // request dropped while blocked leaves no trace
    f_nready = 1'b1;
    @(negedge clk);
    chk("drop_gnt0", bus.wr_gnt0, 0);
    cyc();
    bus.wr_req0 = 1'b0;
    f_nready    = 1'b0;
    @(negedge clk);
    chk("drop_after_wen", bus.dp_wen, 0);
    cyc();

    // reset asserted mid-cycle with both producers and the consumer requesting
    bus.wr_req0 = 1'b1;
    bus.wr_req1 = 1'b1;
    bus.rd_req  = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("mrst_init", bus.dp_init, 1);
    chk("mrst_gnt0", bus.wr_gnt0, 0);
    chk("mrst_gnt1", bus.wr_gnt1, 0);
    chk("mrst_ack",  bus.rd_ack,  0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_init_cycle", bus.dp_init, 1);
    cyc();
    @(negedge clk);
    chk("mrst_first_gnt0", bus.wr_gnt0, 1);
    chk("mrst_first_din",  bus.dp_din,  4'h3);
    cyc();
    bus.wr_req0 = 1'b0;
    bus.wr_req1 = 1'b0;
    bus.rd_req  = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
